apb_xbar_n: RTL and testbench

Parametrised APB interconnect: one APB master (the CPU) fans out to N_SLAVES slaves through a parameter-defined base/mask address map. It replaces the fixed five-slave bus decoder in the SoC top. Three things are added over that decoder:
- an explicit SETUP/ACCESS state machine;
- error responses for unmapped addresses;
- a per-transfer PREADY timeout watchdog, with sticky error capture and an interrupt pulse for the interrupt controller.

---
 rtl/apb_xbar_n_pkg.sv | 30 +++
 rtl/apb_xbar_n_if.sv | 24 ++
 rtl/apb_xbar_n_decoder.sv | 42 ++++
 rtl/apb_xbar_n.sv | 194 +++++++++++++++++++
 tb/tb_apb_xbar_n.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_xbar_n_pkg.sv
// Shared types and sizing helpers for the APB crossbar and its address decoder.
package apb_pkg;

    // Transfer phase tracked by the crossbar; ERR marks a setup that decoded to no slave.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    // Codes reported on err_cause.
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_DECODE  = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } err_cause_e;

    // $clog2 that never returns 0, so a one-slave or watchdog-off build keeps a legal width.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Widths for the default SoC build; parametrised modules derive their own via clog2_min1.
    localparam int unsigned DEF_N_SLAVES = 4;
    localparam int unsigned DEF_TIMEOUT  = 255;
    localparam int unsigned IDX_W        = clog2_min1(DEF_N_SLAVES);
    localparam int unsigned TO_W         = clog2_min1(DEF_TIMEOUT + 1);

endpackage

// File: rtl/apb_xbar_n_if.sv
// Master-side APB request/response bundle (pwdata/pwrite are broadcast elsewhere).
interface apb_xbar_n_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perr;

    // The CPU drives the request and receives the response.
    modport master (
        output paddr, psel, penable,
        input  prdata, pready, perr
    );

    // The interconnect receives the request and returns the response.
    modport slave (
        input  paddr, psel, penable,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_xbar_n_decoder.sv
// Combinational base/mask address matcher; the lowest matching slave index wins.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned                       ADDR_WIDTH = 32,
    parameter int unsigned                       N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0]    SLV_BASE   = '0,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0]    SLV_MASK   = '0,
    localparam int unsigned                      IW         = clog2_min1(N_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [N_SLAVES-1:0]   hit,
    output logic [IW-1:0]         idx,
    output logic                  miss
);

    logic [N_SLAVES-1:0] match;

    // Raw per-slave match, overlaps allowed.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            match[i] = (addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                       == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Priority resolve: scan downwards so the lowest matching index is written last.
    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        miss = ~|match;
    end

endmodule

// File: rtl/apb_xbar_n.sv
// One APB master to N slaves with decode-error responses and a PREADY watchdog.
module apb_xbar_n
    import apb_pkg::*;
#(
    parameter int unsigned                    ADDR_WIDTH = 32,
    parameter int unsigned                    DATA_WIDTH = 32,
    parameter int unsigned                    N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE   = {32'h8002_0000, 32'h8001_0000,
                                                            32'h8000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK   = {32'hFFFF_FF00, 32'hFFFF_FF00,
                                                            32'hFFFF_0000, 32'h8000_0000},
    parameter int unsigned                    TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           APB_PRESETn,
    apb_xbar_n_if.slave                    apb,
    output logic [N_SLAVES-1:0]            s_psel,
    output logic [N_SLAVES-1:0]            s_penable,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [N_SLAVES-1:0]            s_pready,
    input  logic [N_SLAVES-1:0]            s_perr,
    output logic                           err_irq,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    output logic [1:0]                     err_cause
);

    localparam int unsigned IW = clog2_min1(N_SLAVES);
    localparam int unsigned TW = clog2_min1(TIMEOUT + 1);

    apb_state_e            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  err_irq_q, err_irq_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    err_cause_e            err_cause_q, err_cause_d;

    logic [N_SLAVES-1:0]   dec_hit;
    logic [IW-1:0]         dec_idx;
    logic                  dec_miss;

    logic                  setup_cyc;
    logic                  xfer_on;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  to_hit;
    logic                  acc_done;
    logic                  dec_err;
    logic                  log_err;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_SLAVES   (N_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr (apb.paddr),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .miss (dec_miss)
    );

    // Per-cycle qualifiers shared by the FSM, datapath and output mux.
    always_comb begin
        setup_cyc = apb.psel && !apb.penable && (state_q == IDLE || state_q == SETUP);
        xfer_on   = apb.psel && apb.penable;
        sel_ready = s_pready[idx_q];
        sel_err   = s_perr[idx_q];
        sel_data  = s_prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
        // A slave that answers on the expiry cycle still wins.
        to_hit    = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT)) && !sel_ready;
        acc_done  = (state_q == ACCESS) && xfer_on && (sel_ready || to_hit);
        dec_err   = (state_q == ERR) && xfer_on;
        log_err   = dec_err || ((state_q == ACCESS) && xfer_on && to_hit);
    end

    // State register.
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped psel anywhere aborts back to IDLE without logging.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, SETUP: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (!apb.penable) begin
                    state_d = dec_miss ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (acc_done) begin
                    state_d = SETUP;
                end
            end
            ERR: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (apb.penable) begin
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for the captured index, watchdog counter and sticky error record.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_irq_d   = log_err;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        if (setup_cyc) begin
            idx_d = dec_idx;
            cnt_d = '0;
        end else if ((state_q == ACCESS) && xfer_on && !sel_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (log_err) begin
            err_addr_d  = apb.paddr;
            err_cause_d = dec_err ? CAUSE_DECODE : CAUSE_TIMEOUT;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= CAUSE_NONE;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    // Output mux; everything is forced low while reset is asserted, not just at the next edge.
    always_comb begin
        s_psel      = '0;
        s_penable   = '0;
        apb.prdata  = '0;
        apb.pready  = 1'b0;
        apb.perr    = 1'b0;
        if (APB_PRESETn) begin
            case (state_q)
                IDLE, SETUP: begin
                    if (apb.psel) begin
                        s_psel = dec_hit;
                    end
                end
                ACCESS: begin
                    if (apb.psel && !to_hit) begin
                        s_psel[idx_q]    = 1'b1;
                        s_penable[idx_q] = apb.penable;
                        if (apb.penable) begin
                            apb.prdata = sel_data;
                            apb.pready = sel_ready;
                            apb.perr   = sel_err;
                        end
                    end else if (xfer_on && to_hit) begin
                        apb.pready = 1'b1;
                        apb.perr   = 1'b1;
                    end
                end
                ERR: begin
                    if (xfer_on) begin
                        apb.pready = 1'b1;
                        apb.perr   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;

endmodule

// File: tb/tb_apb_xbar_n.sv
// Directed bench with a transfer-level reference model checked every falling edge.
module tb_apb_xbar_n;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 255;

    localparam logic [AW-1:0] BASE [NS] = '{32'h0000_0000, 32'h8000_0000,
                                            32'h8001_0000, 32'h8002_0000};
    localparam logic [AW-1:0] MASK [NS] = '{32'h8000_0000, 32'hFFFF_0000,
                                            32'hFFFF_FF00, 32'hFFFF_FF00};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NS-1:0]        s_psel, s_penable, s_pready, s_perr;
    logic [NS*DW-1:0]     s_prdata;
    logic                 err_irq;
    logic [AW-1:0]        err_addr;
    logic [1:0]           err_cause;

    apb_xbar_n_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_xbar_n #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_SLAVES   (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .APB_PRESETn (rst_n),
        .apb         (bus),
        .s_psel      (s_psel),
        .s_penable   (s_penable),
        .s_prdata    (s_prdata),
        .s_pready    (s_pready),
        .s_perr      (s_perr),
        .err_irq     (err_irq),
        .err_addr    (err_addr),
        .err_cause   (err_cause)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int irq_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_dec(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] onehot(input int t);
        logic [NS-1:0] v;
        v = '0;
        if (t >= 0) v[t] = 1'b1;
        return v;
    endfunction

    // Reference model: one outstanding transfer, its target and how long it has waited.
    bit            m_busy = 1'b0;
    int            m_tgt = 0;
    int            m_wait = 0;
    bit            m_irq = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [1:0]    m_cause = 2'd0;

    always @(negedge clk) begin : cmp
        logic [NS-1:0] e_sel, e_en;
        logic [DW-1:0] e_rd;
        logic          e_rdy, e_err;
        bit            lg;
        logic [1:0]    lg_cause;
        e_sel = '0; e_en = '0; e_rd = '0; e_rdy = 1'b0; e_err = 1'b0;
        lg = 1'b0; lg_cause = 2'd0;
        if (!rst_n) begin
            m_busy = 1'b0; m_irq = 1'b0; m_addr = '0; m_cause = 2'd0;
        end else if (!m_busy) begin
            if (bus.psel) e_sel = onehot(model_dec(bus.paddr));
        end else if (bus.psel && bus.penable) begin
            if (m_tgt < 0) begin
                e_rdy = 1'b1; e_err = 1'b1; lg = 1'b1; lg_cause = 2'd1;
            end else if (m_wait == TO && !s_pready[m_tgt]) begin
                e_rdy = 1'b1; e_err = 1'b1; lg = 1'b1; lg_cause = 2'd2;
            end else begin
                e_sel = onehot(m_tgt);
                e_en  = onehot(m_tgt);
                e_rdy = s_pready[m_tgt];
                e_err = s_perr[m_tgt];
                e_rd  = s_prdata[m_tgt*DW +: DW];
            end
        end

        chk("s_psel", 64'(s_psel), 64'(e_sel));
        chk("s_penable", 64'(s_penable), 64'(e_en));
        chk("prdata", 64'(bus.prdata), 64'(e_rd));
        chk("pready", 64'(bus.pready), 64'(e_rdy));
        chk("perr", 64'(bus.perr), 64'(e_err));
        chk("err_irq", 64'(err_irq), 64'(m_irq));
        chk("err_addr", 64'(err_addr), 64'(m_addr));
        chk("err_cause", 64'(err_cause), 64'(m_cause));
        if (err_irq === 1'b1) irq_seen++;

        // Advance the model to what holds after the coming rising edge.
        if (rst_n) begin
            m_irq = lg;
            if (lg) begin
                m_addr = bus.paddr;
                m_cause = lg_cause;
            end
            if (!m_busy) begin
                if (bus.psel && !bus.penable) begin
                    m_busy = 1'b1;
                    m_tgt = model_dec(bus.paddr);
                    m_wait = 0;
                end
            end else if (!bus.psel) begin
                m_busy = 1'b0;
            end else if (bus.penable) begin
                if (lg || e_rdy) m_busy = 1'b0;
                else m_wait++;
            end
        end
    end

    // One transfer: setup, then access with s_pready rising after 'waits' access cycles.
    task automatic xfer(input logic [AW-1:0] addr, input int waits, input logic [NS-1:0] perr_v,
                        output int cyc, output logic [NS-1:0] sel_at,
                        output logic [DW-1:0] rd_at, output logic err_at);
        cyc = -1; sel_at = '0; rd_at = '0; err_at = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr;
        s_pready = '0; s_perr = perr_v;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        for (int c = 0; c < 600; c++) begin
            s_pready = (c >= waits) ? '1 : '0;
            @(negedge clk);
            if (bus.pready === 1'b1) begin
                cyc = c; sel_at = s_psel; rd_at = bus.prdata; err_at = bus.perr;
            end
            @(posedge clk); #1;
            if (cyc >= 0) break;
        end
        s_pready = '0; s_perr = '0; bus.penable = 1'b0;
        if (cyc < 0) begin
            tests++; fails++;
            $display("FAIL xfer_bound: got no pready expected pready within 600 cycles");
        end
    endtask

    task automatic idle(input int n);
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "bench hung");
    end

    initial begin
        int            cyc;
        logic [NS-1:0] sel;
        logic [DW-1:0] rd;
        logic          er;
        int            irq0;

        rst_n = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0;
        s_pready = '0; s_perr = '0;
        s_prdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        #2;
        chk("rst_s_psel", 64'(s_psel), 64'h0);
        chk("rst_err_cause", 64'(err_cause), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // 1: slave0 read with two wait states
        xfer(32'h0000_0040, 2, '0, cyc, sel, rd, er);
        chk("t1_cycles", 64'(cyc), 64'd2);
        chk("t1_sel", 64'(sel), 64'h1);
        chk("t1_rdata", 64'(rd), 64'hDEAD_BEEF);
        chk("t1_perr", 64'(er), 64'h0);
        idle(2);

        // 2: uart, zero wait states
        xfer(32'h8001_0004, 0, '0, cyc, sel, rd, er);
        chk("t2_cycles", 64'(cyc), 64'd0);
        chk("t2_sel", 64'(sel), 64'h4);
        chk("t2_rdata", 64'(rd), 64'h2222_2222);
        idle(2);

        // 3: unmapped address
        irq0 = irq_seen;
        xfer(32'h9000_0000, 0, '0, cyc, sel, rd, er);
        chk("t3_cycles", 64'(cyc), 64'd0);
        chk("t3_sel", 64'(sel), 64'h0);
        chk("t3_perr", 64'(er), 64'h1);
        chk("t3_rdata", 64'(rd), 64'h0);
        idle(3);
        chk("t3_irq_count", 64'(irq_seen - irq0), 64'd1);
        chk("t3_cause", 64'(err_cause), 64'd1);
        chk("t3_addr", 64'(err_addr), 64'h9000_0000);

        // 4: slave3 never ready, watchdog fires on the 256th access cycle
        irq0 = irq_seen;
        xfer(32'h8002_0010, 100000, '0, cyc, sel, rd, er);
        chk("t4_cycles", 64'(cyc), 64'd255);
        chk("t4_sel", 64'(sel), 64'h0);
        chk("t4_perr", 64'(er), 64'h1);
        // late pready from the abandoned slave must not reach the master
        s_pready = 4'b1000;
        idle(3);
        s_pready = '0;
        chk("t4_irq_count", 64'(irq_seen - irq0), 64'd1);
        chk("t4_cause", 64'(err_cause), 64'd2);
        chk("t4_addr", 64'(err_addr), 64'h8002_0010);

        // 5: ready exactly on the expiry cycle wins, nothing logged
        irq0 = irq_seen;
        xfer(32'h8002_0020, 255, '0, cyc, sel, rd, er);
        chk("t5_cycles", 64'(cyc), 64'd255);
        chk("t5_sel", 64'(sel), 64'h8);
        chk("t5_perr", 64'(er), 64'h0);
        chk("t5_rdata", 64'(rd), 64'h3333_3333);
        idle(3);
        chk("t5_irq_count", 64'(irq_seen - irq0), 64'd0);
        chk("t5_cause_kept", 64'(err_cause), 64'd2);

        // 6: reset in the middle of an access
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0000_0040;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #3;
        chk("t6_pre_sel", 64'(s_psel), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sel", 64'(s_psel), 64'h0);
        chk("t6_rst_en", 64'(s_penable), 64'h0);
        chk("t6_rst_cause", 64'(err_cause), 64'h0);
        chk("t6_rst_addr", 64'(err_addr), 64'h0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        xfer(32'h0000_0080, 1, '0, cyc, sel, rd, er);
        chk("t6a_sel", 64'(sel), 64'h1);
        chk("t6a_rdata", 64'(rd), 64'hDEAD_BEEF);
        // back-to-back: psel still high, slave1 reports its own error
        irq0 = irq_seen;
        xfer(32'h8000_0100, 0, 4'b0010, cyc, sel, rd, er);
        chk("t6b_sel", 64'(sel), 64'h2);
        chk("t6b_rdata", 64'(rd), 64'h1111_1111);
        chk("t6b_perr", 64'(er), 64'h1);
        idle(3);
        chk("t6b_no_irq", 64'(irq_seen - irq0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
